// File: rtl/mem_wb.sv
// MEM/WB pipeline register and write-back data formatter.
// `WB_UNALIGNED_LOAD_EN enables LWL/LWR merging with the old rt value.
module mem_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic        mem_load,
   input  logic [2:0]  mem_load_op,
   input  logic [1:0]  mem_addr_lo,
   input  logic        mem_whilo,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic [31:0] ram_rdata,
   output logic        wb_wreg,
   output logic [4:0]  wb_wd,
   output logic [31:0] wb_wdata,
   output logic        wb_whilo,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_LWL = 3'd5;
   localparam logic [2:0] OP_LWR = 3'd6;

   logic [4:0]  wd_q, wd_d;
   logic        wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic        load_q, load_d;
   logic [2:0]  load_op_q, load_op_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic        whilo_q, whilo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        bubble;
   logic        capture;

   // Only the MEM and WB stall bits matter here.
   logic        unused_stall;
   assign unused_stall = ^stall[3:0];

   assign bubble  = flush | (stall[4] & ~stall[5]);
   assign capture = ~stall[4];

   always_comb begin
      wd_d      = wd_q;
      wreg_d    = wreg_q;
      wdata_d   = wdata_q;
      load_d    = load_q;
      load_op_d = load_op_q;
      addr_lo_d = addr_lo_q;
      whilo_d   = whilo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (bubble) begin
         wd_d      = '0;
         wreg_d    = 1'b0;
         wdata_d   = '0;
         load_d    = 1'b0;
         load_op_d = '0;
         addr_lo_d = '0;
         whilo_d   = 1'b0;
         hi_d      = '0;
         lo_d      = '0;
      end else if (capture) begin
         wd_d      = mem_wd;
         wreg_d    = mem_wreg;
         wdata_d   = mem_wdata;
         load_d    = mem_load;
         load_op_d = mem_load_op;
         addr_lo_d = mem_addr_lo;
         whilo_d   = mem_whilo;
         hi_d      = mem_hi;
         lo_d      = mem_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q      <= '0;
         wreg_q    <= 1'b0;
         wdata_q   <= '0;
         load_q    <= 1'b0;
         load_op_q <= '0;
         addr_lo_q <= '0;
         whilo_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         wd_q      <= wd_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
         load_q    <= load_d;
         load_op_q <= load_op_d;
         addr_lo_q <= addr_lo_d;
         whilo_q   <= whilo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Big-endian lane select: addr_lo 0 is the most significant byte.
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = ram_rdata[31:24];
      unique case (addr_lo_q)
         2'd0: byte_sel = ram_rdata[31:24];
         2'd1: byte_sel = ram_rdata[23:16];
         2'd2: byte_sel = ram_rdata[15:8];
         2'd3: byte_sel = ram_rdata[7:0];
         default: byte_sel = ram_rdata[31:24];
      endcase
      half_sel = addr_lo_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
   end

   logic [31:0] load_data;

   always_comb begin
      load_data = ram_rdata;
      unique case (load_op_q)
         OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: load_data = {24'd0, byte_sel};
         OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU: load_data = {16'd0, half_sel};
`ifdef WB_UNALIGNED_LOAD_EN
         OP_LWL: begin
            unique case (addr_lo_q)
               2'd0: load_data = ram_rdata;
               2'd1: load_data = {ram_rdata[23:0], wdata_q[7:0]};
               2'd2: load_data = {ram_rdata[15:0], wdata_q[15:0]};
               2'd3: load_data = {ram_rdata[7:0], wdata_q[23:0]};
               default: load_data = ram_rdata;
            endcase
         end
         OP_LWR: begin
            unique case (addr_lo_q)
               2'd0: load_data = {wdata_q[31:8], ram_rdata[31:24]};
               2'd1: load_data = {wdata_q[31:16], ram_rdata[31:16]};
               2'd2: load_data = {wdata_q[31:24], ram_rdata[31:8]};
               2'd3: load_data = ram_rdata;
               default: load_data = ram_rdata;
            endcase
         end
`else
         OP_LWL: load_data = ram_rdata;
         OP_LWR: load_data = ram_rdata;
`endif
         OP_LW:  load_data = ram_rdata;
         default: load_data = ram_rdata;
      endcase
   end

   assign wb_wdata = load_q ? load_data : wdata_q;
   assign wb_wreg  = wreg_q;
   assign wb_wd    = wd_q;
   assign wb_whilo = whilo_q;
   assign wb_hi    = hi_q;
   assign wb_lo    = lo_q;

endmodule

// File: tb/tb_mem_wb.sv
// Randomized and directed bench for mem_wb against a behavioural model.
// Honours `WB_UNALIGNED_LOAD_EN the same way the design does.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_load;
   logic [2:0]  mem_load_op;
   logic [1:0]  mem_addr_lo;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [31:0] ram_rdata;
   logic        wb_wreg;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;
   logic        wb_whilo;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;

   always #5 clk = ~clk;

   mem_wb dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_load(mem_load), .mem_load_op(mem_load_op),
      .mem_addr_lo(mem_addr_lo), .mem_whilo(mem_whilo),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .ram_rdata(ram_rdata),
      .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
   );

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        load;
      logic [2:0]  op;
      logic [1:0]  a;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
   } wb_t;

   wb_t m;
   wb_t zero_s;
   int  total = 0;
   int  bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_wdata(input wb_t s,
                                             input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      logic [63:0] mask;
      logic [63:0] r;
      int          ai;
      ai = int'(s.a);
      if (!s.load) return s.wdata;
      b = (rd >> (8 * (3 - ai))) & 32'hFF;
      h = (rd >> (16 * (1 - ai / 2))) & 32'hFFFF;
      r = 64'(rd);
      case (s.op)
         3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd2: return b;
         3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4: return h;
`ifdef WB_UNALIGNED_LOAD_EN
         3'd5: begin
            mask = (64'd1 << (8 * ai)) - 64'd1;
            return 32'((r << (8 * ai)) | (64'(s.wdata) & mask));
         end
         3'd6: begin
            mask = (64'd1 << (8 * (ai + 1))) - 64'd1;
            return 32'((r >> (8 * (3 - ai))) | (64'(s.wdata) & ~mask));
         end
`endif
         default: return rd;
      endcase
   endfunction

   // One clock: model the register update on the edge, settle at negedge.
   task automatic cycle();
      @(posedge clk);
      if (rst || flush || (stall[4] && !stall[5])) m = zero_s;
      else if (!stall[4]) begin
         m.wd = mem_wd; m.wreg = mem_wreg; m.wdata = mem_wdata;
         m.load = mem_load; m.op = mem_load_op; m.a = mem_addr_lo;
         m.whilo = mem_whilo; m.hi = mem_hi; m.lo = mem_lo;
      end
      @(negedge clk);
   endtask

   task automatic compare_all(input string tag);
      #1;
      check({tag, ".wreg"}, 32'(wb_wreg), 32'(m.wreg));
      check({tag, ".wd"}, 32'(wb_wd), 32'(m.wd));
      check({tag, ".wdata"}, wb_wdata, exp_wdata(m, ram_rdata));
      check({tag, ".whilo"}, 32'(wb_whilo), 32'(m.whilo));
      check({tag, ".hi"}, wb_hi, m.hi);
      check({tag, ".lo"}, wb_lo, m.lo);
   endtask

   task automatic rand_mem();
      mem_wd = 5'($urandom);
      mem_wreg = 1'($urandom);
      mem_wdata = $urandom;
      mem_load = 1'($urandom);
      mem_load_op = 3'($urandom);
      mem_addr_lo = 2'($urandom);
      mem_whilo = 1'($urandom);
      mem_hi = $urandom;
      mem_lo = $urandom;
   endtask

   task automatic set_alu(input logic [4:0] wd, input logic [31:0] d);
      mem_wd = wd; mem_wreg = 1'b1; mem_wdata = d; mem_load = 1'b0;
      mem_load_op = 3'd0; mem_addr_lo = 2'd0; mem_whilo = 1'b0;
      mem_hi = '0; mem_lo = '0;
   endtask

   task automatic set_load(input logic [2:0] op, input logic [1:0] a,
                           input logic [31:0] rt);
      mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = rt; mem_load = 1'b1;
      mem_load_op = op; mem_addr_lo = a; mem_whilo = 1'b0;
   endtask

   initial begin
      zero_s = '{default: '0};
      m = zero_s;
      rst = 1'b1; stall = '0; flush = 1'b0; ram_rdata = 32'hDEAD_BEEF;
      rand_mem();
      mem_wreg = 1'b1; mem_whilo = 1'b1; mem_wd = 5'd7;
      @(negedge clk);

      // reset with nonzero inputs
      cycle(); compare_all("rst1");
      check("rst1.wdata0", wb_wdata, 32'd0);
      check("rst1.wreg0", 32'(wb_wreg), 32'd0);
      cycle(); compare_all("rst2");
      rst = 1'b0;

      // plain ALU write
      set_alu(5'd3, 32'h1234_5678);
      cycle(); compare_all("alu");
      check("alu.wd", 32'(wb_wd), 32'd3);
      check("alu.wdata", wb_wdata, 32'h1234_5678);

      // byte / halfword loads
      set_load(3'd1, 2'd0, 32'h0);
      cycle(); ram_rdata = 32'h80FF_7F01; compare_all("lb");
      check("lb.val", wb_wdata, 32'hFFFF_FF80);
      set_load(3'd2, 2'd0, 32'h0);
      cycle(); compare_all("lbu");
      check("lbu.val", wb_wdata, 32'h0000_0080);
      set_load(3'd3, 2'd2, 32'h0);
      cycle(); compare_all("lh");
      check("lh.val", wb_wdata, 32'h0000_7F01);

      // hold, bubble, hold
      set_alu(5'd4, 32'hCAFE_0001);
      cycle(); compare_all("cap");
      set_alu(5'd5, 32'h0BAD_0BAD);
      stall = 6'b11_1111;
      cycle(); compare_all("hold");
      check("hold.wdata", wb_wdata, 32'hCAFE_0001);
      stall = 6'b01_1111;
      cycle(); compare_all("bub");
      check("bub.wreg", 32'(wb_wreg), 32'd0);
      check("bub.wdata", wb_wdata, 32'd0);
      stall = 6'b11_1111;
      cycle(); compare_all("hold0");

      // flush, and flush beating stall
      stall = '0;
      set_alu(5'd6, 32'h1111_2222); mem_whilo = 1'b1;
      cycle(); compare_all("pre_fl");
      set_alu(5'd7, 32'h3333_4444); mem_whilo = 1'b1; flush = 1'b1;
      cycle(); compare_all("flush");
      check("flush.wreg", 32'(wb_wreg), 32'd0);
      check("flush.whilo", 32'(wb_whilo), 32'd0);
      flush = 1'b0;
      cycle();
      stall = 6'b11_0000; flush = 1'b1;
      cycle(); compare_all("fl_st");
      check("fl_st.wreg", 32'(wb_wreg), 32'd0);
      flush = 1'b0; stall = '0;

      // unaligned left load
      set_load(3'd5, 2'd1, 32'hAABB_CCDD);
      cycle(); ram_rdata = 32'h1122_3344; compare_all("lwl");
`ifdef WB_UNALIGNED_LOAD_EN
      check("lwl.val", wb_wdata, 32'h2233_44DD);
`else
      check("lwl.val", wb_wdata, 32'h1122_3344);
`endif

      // reset mid-operation under stall
      set_alu(5'd8, 32'h5555_AAAA);
      cycle();
      rst = 1'b1; stall = 6'b11_1111;
      cycle(); compare_all("mrst");
      check("mrst.wd", 32'(wb_wd), 32'd0);
      rst = 1'b0; stall = '0;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rand_mem();
         rst = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 5))
            0: stall = 6'b01_1111;
            1: stall = 6'b11_1111;
            2: stall = 6'($urandom);
            default: stall = 6'($urandom) & 6'b00_1111;
         endcase
         cycle();
         ram_rdata = $urandom;
         compare_all("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register and write-back stage between the memory access stage and the general-purpose register file. Captures MEM-stage results each cycle under stall/flush control, and in the WB cycle forms the final register write value. For loads, it extracts and extends the addressed byte or halfword from the synchronous data-RAM read word. Drives the register file write port (enable, address, data) and the HI/LO write port.

## Interface
Parameters:
- none; widths fixed: data 32, register address 5, load op 3.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
- flush  in  1  exception flush; kills the instruction being captured
- mem_wd  in  5  destination register address
- mem_wreg  in  1  register write enable
- mem_wdata  in  32  ALU result; for LWL/LWR, the old rt value
- mem_load  in  1  instruction is a load
- mem_load_op  in  3  load kind: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
- mem_addr_lo  in  2  low two bits of load effective address
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  32 each  HI/LO values
- ram_rdata  in  32  data-RAM read word; valid in the WB cycle (RAM registered by the MEM-cycle address)
- wb_wreg  out  1  register file write enable
- wb_wd  out  5  register file write address
- wb_wdata  out  32  register file write data
- wb_whilo  out  1  HI/LO write enable
- wb_hi, wb_lo  out  32 each  HI/LO write data

## Operation
- Registered fields: wd, wreg, wdata, load, load_op, addr_lo, whilo, hi, lo.
- Per-edge update, priority order:
  - rst: all fields 0
  - flush: all fields 0 (bubble)
  - stall[4]=1 and stall[5]=0: all fields 0 (bubble into WB)
  - stall[4]=0: capture mem_* inputs
  - otherwise: hold
- wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo: driven directly from the registered fields.
- wb_wdata, combinational:
  - load=0: registered wdata.
  - load=1: derived from ram_rdata as below. Big-endian byte order: addr_lo 0 selects ram_rdata[31:24], 3 selects [7:0].
- Load data forms:
  - LB / LBU: selected byte, sign- / zero-extended.
  - LH / LHU: addr_lo[1]=0 selects [31:16], 1 selects [15:0]; sign- / zero-extended. addr_lo[0] is ignored; misalignment traps upstream.
  - LW and code 7: ram_rdata.
  - LWL / LWR: see Configuration.
- The register-zero write block and same-cycle read bypass belong to the register file, not this block. wb_wreg=1 with wb_wd=0 is legal output.

## Timing
- Latency: MEM inputs appear on wb_* one edge after capture.
- wb_wdata for loads depends combinationally on ram_rdata in the same WB cycle. There are no registers on the output path.
- Reset values: every wb_* output is 0. wb_wdata is 0 because load=0 and wdata=0.
- Mid-operation reset: takes effect at the next edge regardless of stall or flush. The in-flight instruction is discarded.
- Simultaneous flush and stall: flush wins and inserts a bubble.
- stall[5]=1: contents held. wb_wreg stays asserted for a held write; repeated identical writes are harmless.

## Configuration
- Macro: `WB_UNALIGNED_LOAD_EN`.
- Defined: LWL/LWR merge ram_rdata with the registered wdata (old rt).
  - LWL by addr_lo:
    - 0: rdata
    - 1: {rdata[23:0], rt[7:0]}
    - 2: {rdata[15:0], rt[15:0]}
    - 3: {rdata[7:0], rt[23:0]}
  - LWR by addr_lo:
    - 0: {rt[31:8], rdata[31:24]}
    - 1: {rt[31:16], rdata[31:16]}
    - 2: {rt[31:24], rdata[31:8]}
    - 3: rdata
- Undefined: load_op 5 and 6 behave as LW. mem_wdata is ignored for all loads.

## Test plan
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> all wb_* outputs are 0 after the first edge.
- ALU write: mem_wd=5'd3, mem_wreg=1, mem_wdata=32'h1234_5678, stall=0 -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=32'h1234_5678.
- LB/LBU/LH: ram_rdata=32'h80FF_7F01.
  - LB with addr_lo=0 -> 32'hFFFF_FF80.
  - LBU with addr_lo=0 -> 32'h0000_0080.
  - LH with addr_lo=2 -> 32'h0000_7F01.
- Stall bubble: stall=6'b01_1111 with a valid MEM write -> next cycle wb_wreg=0 and wb_wdata=0. Then stall=6'b11_1111 -> outputs hold.
- Flush: flush=1 with stall=0 and mem_wreg=1, mem_whilo=1 -> next cycle wb_wreg=0 and wb_whilo=0.
- Unaligned (macro defined): LWL, addr_lo=1, rt=32'hAABB_CCDD, ram_rdata=32'h1122_3344 -> wb_wdata=32'h2233_44DD. Undefined: same stimulus -> 32'h1122_3344.
